// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - fixed-latency instruction memory responder for the fetch path
// One fetch in flight at a time; program-load port writes the array independently.
module instr_mem_responder #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [7:0]        req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_misaligned,
   input  logic              resp_ready,
   input  logic              prog_we,
   input  logic [5:0]        prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic [3:0]        cnt;
   logic [7:0]        addr_q;
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid)  state_next = WAIT;
         WAIT:    if (cnt == 4'd0) state_next = RESP;
         RESP:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      busy       = (state != IDLE);
   end

   // Memory is deliberately left out of reset; loads on a reset edge still land.
   always_ff @(posedge clk) begin
      if (prog_we) mem[prog_addr] <= prog_data;
   end

   // The capture read samples mem before any same-edge write, giving read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt             <= 4'd0;
         addr_q          <= 8'd0;
         resp_data       <= '0;
         resp_misaligned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  cnt    <= 4'(LATENCY - 1);
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_data       <= mem[addr_q[7:2]];
                  resp_misaligned <= (addr_q[1:0] != 2'b00);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - scoreboard bench for instr_mem_responder
// Three instances share clock, reset and program port; they differ only in LATENCY (2, 1, 15).
module tb_instr_mem_responder;

   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [5:0]  prog_addr;
   logic [31:0] prog_data;
   logic        req_valid [N];
   logic [7:0]  req_addr [N];
   logic        req_ready [N];
   logic        resp_valid [N];
   logic [31:0] resp_data [N];
   logic        resp_misaligned [N];
   logic        resp_ready [N];
   logic        busy [N];

   logic [31:0] model_mem [64];
   logic [32:0] sb [$];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      instr_mem_responder #(
         .DATA_W(32), .DEPTH(64), .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) dut (
         .clk(clk), .reset(reset),
         .req_valid(req_valid[g]), .req_addr(req_addr[g]), .req_ready(req_ready[g]),
         .resp_valid(resp_valid[g]), .resp_data(resp_data[g]),
         .resp_misaligned(resp_misaligned[g]), .resp_ready(resp_ready[g]),
         .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
         .busy(busy[g])
      );
   end

   function automatic int lat_of(int d);
      return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input logic [5:0] a, input logic [31:0] v);
      prog_we = 1'b1; prog_addr = a; prog_data = v;
      step();
      prog_we = 1'b0;
      model_mem[a] = v;
   endtask

   task automatic check_idle(int d, string tag);
      check({tag, "_resp_valid"}, 64'(resp_valid[d]), 64'd0);
      check({tag, "_req_ready"}, 64'(req_ready[d]), 64'd1);
      check({tag, "_busy"}, 64'(busy[d]), 64'd0);
   endtask

   // hold: cycles resp_ready stays low in RESP; coll: write 0x22222222 to the fetched word on the capture edge
   task automatic fetch(int d, logic [7:0] a, int hold, bit coll);
      logic [32:0] exp;
      int          edges;
      check("pre_req_ready", 64'(req_ready[d]), 64'd1);
      req_valid[d] = 1'b1; req_addr[d] = a; resp_ready[d] = (hold == 0);
      step();
      req_valid[d] = 1'b0;
      sb.push_back({a[1:0] != 2'b00, model_mem[a[7:2]]});
      check("acc_req_ready", 64'(req_ready[d]), 64'd0);
      check("acc_busy", 64'(busy[d]), 64'd1);
      edges = 0;
      while (!resp_valid[d] && edges < 40) begin
         if (coll && edges + 1 == lat_of(d)) begin
            prog_we = 1'b1; prog_addr = a[7:2]; prog_data = 32'h22222222;
         end
         step();
         edges++;
         if (prog_we) begin
            prog_we = 1'b0;
            model_mem[a[7:2]] = 32'h22222222;
         end
      end
      if (!resp_valid[d]) begin
         check("resp_timeout", 64'd0, 64'd1);
         void'(sb.pop_front());
         return;
      end
      check("latency", 64'(edges), 64'(lat_of(d)));
      exp = sb.pop_front();
      check("resp_data", 64'(resp_data[d]), 64'(exp[31:0]));
      check("resp_misaligned", 64'(resp_misaligned[d]), 64'(exp[32]));
      for (int i = 0; i < hold; i++) begin
         req_valid[d] = 1'b1; req_addr[d] = 8'h00;
         step();
         check("bp_resp_valid", 64'(resp_valid[d]), 64'd1);
         check("bp_resp_data", 64'(resp_data[d]), 64'(exp[31:0]));
         check("bp_req_ready", 64'(req_ready[d]), 64'd0);
      end
      req_valid[d] = 1'b0; resp_ready[d] = 1'b1;
      step();
      check_idle(d, "done");
   endtask

   task automatic reset_mid(int d, logic [7:0] a, bit in_resp);
      int edges;
      req_valid[d] = 1'b1; req_addr[d] = a; resp_ready[d] = 1'b0;
      step();
      req_valid[d] = 1'b0;
      edges = 0;
      while (in_resp && !resp_valid[d] && edges < 40) begin
         step();
         edges++;
      end
      check(in_resp ? "rst_pre_resp" : "rst_pre_wait", 64'(resp_valid[d]), 64'(in_resp));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle(d, "rst");
      check("rst_resp_data", 64'(resp_data[d]), 64'd0);
      check("rst_misaligned", 64'(resp_misaligned[d]), 64'd0);
      resp_ready[d] = 1'b1;
      for (int i = 0; i < lat_of(d) + 3; i++) begin
         step();
         check("rst_no_resp", 64'(resp_valid[d]), 64'd0);
      end
   endtask

   initial begin
      reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      for (int d = 0; d < N; d++) begin
         req_valid[d] = 1'b0; req_addr[d] = '0; resp_ready[d] = 1'b1;
      end
      step();
      step();
      reset = 1'b0;
      for (int d = 0; d < N; d++) begin
         check_idle(d, "init");
         check("init_resp_data", 64'(resp_data[d]), 64'd0);
      end

      prog(6'd3, 32'h8C220004);
      prog(6'd63, 32'hDEADBEEF);
      prog(6'd5, 32'h11111111);
      prog(6'd0, 32'h12345678);

      fetch(0, 8'h0C, 0, 1'b0);
      fetch(0, 8'h0C, 5, 1'b0);
      fetch(0, 8'h0E, 0, 1'b0);
      fetch(0, 8'hFC, 0, 1'b0);
      fetch(0, 8'h00, 0, 1'b0);
      fetch(0, 8'h14, 0, 1'b1);
      fetch(0, 8'h14, 0, 1'b0);
      check("coll_model", 64'(model_mem[5]), 64'h22222222);

      reset_mid(0, 8'h0C, 1'b0);
      reset_mid(0, 8'hFC, 1'b1);
      fetch(0, 8'h0C, 0, 1'b0);
      fetch(0, 8'hFC, 0, 1'b0);

      fetch(1, 8'h0C, 0, 1'b0);
      fetch(1, 8'h15, 1, 1'b1);
      fetch(2, 8'h0C, 0, 1'b0);
      fetch(2, 8'hFD, 2, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [7:0] a;
         int         w;
         w = $urandom_range(0, 3);
         a = {(w == 0) ? 6'd0 : (w == 1) ? 6'd3 : (w == 2) ? 6'd5 : 6'd63, 2'($urandom_range(0, 3))};
         fetch($urandom_range(0, 1), a, $urandom_range(0, 2), 1'b0);
      end

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Instruction-memory responder for the CPU fetch path. Accepts one fetch request at a time on a valid/ready request channel, waits a fixed number of wait-state cycles, then returns the 32-bit instruction word on a valid/ready response channel. The request address is the 8-bit byte address produced by the program counter. A separate program-load write port fills the memory before or during execution.

## Interface

Parameters:
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 64: number of words. Indexed by `req_addr[7:2]`.
- `LATENCY`, 2: wait-state cycles from request acceptance to response. Legal range 1..15.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: fetch request present.
- `req_addr`, in, 8: byte address of the fetch.
- `req_ready`, out, 1: responder can accept a request.
- `resp_valid`, out, 1: `resp_data` and `resp_misaligned` are valid.
- `resp_data`, out, DATA_W: fetched instruction word.
- `resp_misaligned`, out, 1: the accepted `req_addr[1:0]` was nonzero.
- `resp_ready`, in, 1: consumer takes the response.
- `prog_we`, in, 1: program-load write enable.
- `prog_addr`, in, 6: word index for the program-load write.
- `prog_data`, in, DATA_W: word to write.
- `busy`, out, 1: a request is outstanding (state is not IDLE).

## Operation

- The FSM has three states: IDLE, WAIT, RESP.
- Outputs are decoded from registered state:
  - `req_ready` = (state == IDLE).
  - `resp_valid` = (state == RESP).
  - `busy` = (state != IDLE).
- **IDLE.** On an edge with `req_valid && req_ready`:
  - latch `req_addr`;
  - load the wait counter with `LATENCY-1`;
  - go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT.** Each edge:
  - If the counter is nonzero, decrement it.
  - If the counter is 0:
    - `resp_data <= mem[addr_q[7:2]]`;
    - `resp_misaligned <= (addr_q[1:0] != 0)`;
    - go to RESP.
  - `req_valid` is ignored in WAIT.
- **RESP.**
  - `resp_data` and `resp_misaligned` are held stable while `resp_valid && !resp_ready`.
  - On an edge with `resp_ready`, go to IDLE.
  - A new request cannot be accepted on the same edge the response is consumed, because `req_ready` is low in RESP.
- **Misaligned fetch.** The word is still read using `addr_q[7:2]`. The error is reported only through the flag; the consumer decides how to handle it.
- **Program load.**
  - `prog_we` writes `mem[prog_addr] <= prog_data` at the edge, in any FSM state.
  - It is independent of the handshake and has no back-pressure.
- **Write/read collision.** If a write hits the same word on the WAIT capture edge, the response returns the old contents (read-before-write). The new value is visible to later fetches.
- **Memory contents** are not cleared by reset.

## Timing

- **Reset** (edge with `reset` = 1) overrides everything, including a request or response in progress:
  - state becomes IDLE and the counter is 0;
  - `resp_data` = 0, `resp_misaligned` = 0, `addr_q` = 0;
  - therefore `req_ready` = 1, `resp_valid` = 0, `busy` = 0 after the reset edge.
  - An outstanding request is dropped and no response is produced.
  - A `prog_we` write on the reset edge is still performed.
- **Latency:** if the request is accepted at edge E, `resp_valid` rises after edge E+LATENCY. For example, with LATENCY=1 it rises after the next edge.
- **Throughput:** with `resp_ready` held high, one request completes every LATENCY+2 cycles (accept, LATENCY wait edges, consume edge, then IDLE for 1 cycle).
- **No combinational paths** from inputs to outputs. All outputs are functions of registered state.
- **Address wrap:** `req_addr` 0xFC maps to word 63 and 0x00 maps to word 0. No out-of-range case exists when DEPTH = 64.

## Test plan

- **Basic fetch.** Load `mem[3]` = 0x8C220004 via `prog_we`. With LATENCY=2, send request `req_addr`=0x0C held 1 cycle, `resp_ready`=1.
  - Required: `req_ready` falls after the accept edge; `resp_valid`=1 exactly 2 edges later with data 0x8C220004 and `resp_misaligned`=0; IDLE again 1 edge later.
- **Back-pressure.** As in the basic fetch, but hold `resp_ready`=0 for 5 cycles.
  - Required: `resp_valid` stays 1, `resp_data` stays stable, `req_ready` stays 0, and a second `req_valid` is ignored. Raising `resp_ready` returns the FSM to IDLE on the next edge.
- **Misaligned and wrap.** Request 0x0E.
  - Required: `resp_data` = `mem[3]`, `resp_misaligned`=1.
  - Then request 0xFC. Required: `resp_data` = `mem[63]`, `resp_misaligned`=0.
- **Collision.** `mem[5]` = 0x11111111. Request 0x14, and on the capture edge write `prog_addr`=5 with 0x22222222.
  - Required: the response is 0x11111111.
  - An immediate re-fetch of 0x14 returns 0x22222222.
- **Reset mid-operation.** Assert `reset` for 1 cycle while in WAIT, and again in a separate run while in RESP.
  - Required after the reset edge: `resp_valid`=0, `resp_data`=0, `req_ready`=1, `busy`=0.
  - No response appears for the dropped request; memory contents are unchanged.
- **LATENCY sweep.** Run the basic fetch with LATENCY=1 and LATENCY=15.
  - Required: the first `resp_valid` appears exactly LATENCY edges after the accept edge.
